// File: rtl/zeroriscy_multdiv_arbiter.sv
// Round-robin arbiter that shares one iterative multiply/divide unit between
// two requesters. The winning request's operands are latched on the grant
// edge and the unit's enables/operands are driven only from those latches, so
// they stay stable for the whole operation. The result is captured on the
// unit's ready and handed back through a per-requester rvalid/rready response.
// The unit's active-low reset is expected to be driven from ~rst so that a
// reset mid-operation aborts both blocks coherently.
module zeroriscy_multdiv_arbiter #(
  parameter logic PRIO_INIT = 1'b0,
  parameter int   CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_i,
  output logic [1:0]       gnt_o,
  input  logic [3:0]       req_operator_i,
  input  logic [3:0]       req_signed_i,
  input  logic [63:0]      req_op_a_i,
  input  logic [63:0]      req_op_b_i,
  input  logic [1:0]       flush_i,
  output logic [1:0]       rvalid_o,
  input  logic [1:0]       rready_i,
  output logic [31:0]      rdata_o,
  output logic             md_mult_en_o,
  output logic             md_div_en_o,
  output logic [1:0]       md_operator_o,
  output logic [1:0]       md_signed_mode_o,
  output logic [31:0]      md_op_a_o,
  output logic [31:0]      md_op_b_o,
  input  logic             md_ready_i,
  input  logic [31:0]      md_result_i,
  output logic             busy_o,
  output logic [CNT_W-1:0] busy_cnt_o
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    RESP = 2'b10,
    DROP = 2'b11
  } state_e;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_e           state_r;
  state_e           state_s;
  logic             owner_r;
  logic             prio_r;
  logic [1:0]       operator_r;
  logic [1:0]       signed_r;
  logic [31:0]      op_a_r;
  logic [31:0]      op_b_r;
  logic [31:0]      result_r;
  logic [1:0]       rvalid_r;
  logic             mult_en_r;
  logic             div_en_r;
  logic             busy_r;
  logic [CNT_W-1:0] busy_cnt_r;

  logic             grant_ok_s;
  logic [1:0]       gnt_s;
  logic             gnt_id_s;
  logic             gnt_valid_s;
  logic             owner_flush_s;
  logic             owner_rready_s;
  logic [1:0]       sel_operator_s;
  logic [1:0]       sel_signed_s;
  logic [31:0]      sel_op_a_s;
  logic [31:0]      sel_op_b_s;
  logic             next_owner_s;
  logic [1:0]       next_operator_s;
  logic             mult_en_s;
  logic             div_en_s;
  logic [1:0]       rvalid_s;

  assign owner_flush_s  = flush_i[owner_r];
  assign owner_rready_s = rready_i[owner_r];

  // A new grant may only be issued when idle, or when the owner is taking its
  // result this very cycle (a flush in that cycle wins and blocks the grant).
  always_comb begin
    grant_ok_s = 1'b0;
    if (state_r == IDLE) begin
      grant_ok_s = 1'b1;
    end else if (state_r == RESP) begin
      grant_ok_s = owner_rready_s & ~owner_flush_s;
    end else begin
      grant_ok_s = 1'b0;
    end
  end

  // Round-robin pick between the two requesters; prio_r breaks ties.
  always_comb begin
    gnt_s    = 2'b00;
    gnt_id_s = 1'b0;
    if (grant_ok_s) begin
      case (req_i)
        2'b01: begin
          gnt_s    = 2'b01;
          gnt_id_s = 1'b0;
        end
        2'b10: begin
          gnt_s    = 2'b10;
          gnt_id_s = 1'b1;
        end
        2'b11: begin
          if (prio_r) begin
            gnt_s    = 2'b10;
            gnt_id_s = 1'b1;
          end else begin
            gnt_s    = 2'b01;
            gnt_id_s = 1'b0;
          end
        end
        default: begin
          gnt_s    = 2'b00;
          gnt_id_s = 1'b0;
        end
      endcase
    end else begin
      gnt_s    = 2'b00;
      gnt_id_s = 1'b0;
    end
  end

  assign gnt_valid_s = |gnt_s;
  assign gnt_o       = gnt_s;

  // Operand selection for the requester being granted this cycle.
  always_comb begin
    sel_operator_s = req_operator_i[1:0];
    sel_signed_s   = req_signed_i[1:0];
    sel_op_a_s     = req_op_a_i[31:0];
    sel_op_b_s     = req_op_b_i[31:0];
    if (gnt_id_s) begin
      sel_operator_s = req_operator_i[3:2];
      sel_signed_s   = req_signed_i[3:2];
      sel_op_a_s     = req_op_a_i[63:32];
      sel_op_b_s     = req_op_b_i[63:32];
    end else begin
      sel_operator_s = req_operator_i[1:0];
      sel_signed_s   = req_signed_i[1:0];
      sel_op_a_s     = req_op_a_i[31:0];
      sel_op_b_s     = req_op_b_i[31:0];
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (gnt_valid_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (md_ready_i) begin
          if (owner_flush_s) begin
            state_s = IDLE;
          end else begin
            state_s = RESP;
          end
        end else if (owner_flush_s) begin
          state_s = DROP;
        end else begin
          state_s = RUN;
        end
      end
      DROP: begin
        if (md_ready_i) begin
          state_s = IDLE;
        end else begin
          state_s = DROP;
        end
      end
      RESP: begin
        if (owner_flush_s) begin
          state_s = IDLE;
        end else if (owner_rready_s) begin
          if (gnt_valid_s) begin
            state_s = RUN;
          end else begin
            state_s = IDLE;
          end
        end else begin
          state_s = RESP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM output logic: next values of the registered enables and rvalid,
  // derived from the next state and the operation that will be latched.
  always_comb begin
    mult_en_s       = 1'b0;
    div_en_s        = 1'b0;
    rvalid_s        = 2'b00;
    next_owner_s    = owner_r;
    next_operator_s = operator_r;
    if (gnt_valid_s) begin
      next_owner_s    = gnt_id_s;
      next_operator_s = sel_operator_s;
    end else begin
      next_owner_s    = owner_r;
      next_operator_s = operator_r;
    end
    case (state_s)
      RUN, DROP: begin
        mult_en_s = ~next_operator_s[1];
        div_en_s  = next_operator_s[1];
      end
      RESP: begin
        if (next_owner_s) begin
          rvalid_s = 2'b10;
        end else begin
          rvalid_s = 2'b01;
        end
      end
      default: begin
        mult_en_s = 1'b0;
        div_en_s  = 1'b0;
        rvalid_s  = 2'b00;
      end
    endcase
  end

  // Registered handshake outputs and unit enables.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mult_en_r <= 1'b0;
      div_en_r  <= 1'b0;
      rvalid_r  <= 2'b00;
      busy_r    <= 1'b0;
    end else begin
      mult_en_r <= mult_en_s;
      div_en_r  <= div_en_s;
      rvalid_r  <= rvalid_s;
      busy_r    <= (state_s != IDLE);
    end
  end

  // Operation latch: captured only on a grant edge, held for the whole op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_r    <= 1'b0;
      prio_r     <= PRIO_INIT;
      operator_r <= 2'b00;
      signed_r   <= 2'b00;
      op_a_r     <= 32'h0000_0000;
      op_b_r     <= 32'h0000_0000;
    end else if (gnt_valid_s) begin
      owner_r    <= gnt_id_s;
      prio_r     <= ~gnt_id_s;
      operator_r <= sel_operator_s;
      signed_r   <= sel_signed_s;
      op_a_r     <= sel_op_a_s;
      op_b_r     <= sel_op_b_s;
    end else begin
      owner_r    <= owner_r;
      prio_r     <= prio_r;
      operator_r <= operator_r;
      signed_r   <= signed_r;
      op_a_r     <= op_a_r;
      op_b_r     <= op_b_r;
    end
  end

  // Result capture on the unit's last cycle, unless the owner is discarding it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      result_r <= 32'h0000_0000;
    end else if ((state_r == RUN) && md_ready_i && !owner_flush_s) begin
      result_r <= md_result_i;
    end else begin
      result_r <= result_r;
    end
  end

  // Saturating count of cycles spent in RUN.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_cnt_r <= {CNT_W{1'b0}};
    end else if ((state_r == RUN) && (busy_cnt_r != CNT_MAX)) begin
      busy_cnt_r <= busy_cnt_r + CNT_ONE;
    end else begin
      busy_cnt_r <= busy_cnt_r;
    end
  end

  assign rvalid_o         = rvalid_r;
  assign rdata_o          = result_r;
  assign md_mult_en_o     = mult_en_r;
  assign md_div_en_o      = div_en_r;
  assign md_operator_o    = operator_r;
  assign md_signed_mode_o = signed_r;
  assign md_op_a_o        = op_a_r;
  assign md_op_b_o        = op_b_r;
  assign busy_o           = busy_r;
  assign busy_cnt_o       = busy_cnt_r;

endmodule
